// File: rtl/transport_down.sv
// Purpose: AXI-Stream slave to PAICore send path through a DEPTH-word register FIFO, with tx start/done control. Optional TRANSPORT_DOWN_FILTER_EN drops all-ones marker words.
// Latency: a word accepted at edge N is first presented to PAICore in cycle N+1; sustains 1 word/cycle.
// Backpressure: s_axis_tready drops when the FIFO is full or the block is not in RUN; o_send_valid/o_send_tdata hold while i_send_ready is low.
module transport_down #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 32
) (
    input  logic                     s_axis_aclk,
    input  logic                     s_axis_areset,
    input  logic [63:0]              s_axis_tdata,
    input  logic                     s_axis_tvalid,
    input  logic                     s_axis_tlast,
    output logic                     s_axis_tready,
    output logic                     s_axis_hsked,
    output logic                     o_send_valid,
    output logic [63:0]              o_send_tdata,
    input  logic                     i_send_ready,
    input  logic                     i_tx_sending,
    output logic                     o_tx_done,
    output logic [CNT_W-1:0]         o_frame_cnt,
    output logic [$clog2(DEPTH):0]   o_fifo_level
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]  state;
    logic [63:0] mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] level;
    logic        empty;
    logic        full;
    logic        active;
    logic        push;
    logic        pop;
    logic        empty_after_pop;
    logic [CNT_W-1:0] frame_cnt;

    assign level = wr_ptr - rd_ptr;
    assign empty = (level == '0);
    assign full  = (level == (AW+1)'(DEPTH));

    // Dropping i_tx_sending gates both sides in the same cycle, so an abort never moves data.
    assign active = ~s_axis_areset & i_tx_sending & ((state == RUN) | (state == FLUSH));

    assign s_axis_tready = active & (state == RUN) & ~full;
    assign s_axis_hsked  = s_axis_tvalid & s_axis_tready;
    assign o_send_valid  = active & ~empty;
    assign o_send_tdata  = mem[rd_ptr[AW-1:0]];
    assign pop           = o_send_valid & i_send_ready;

`ifdef TRANSPORT_DOWN_FILTER_EN
    assign push = s_axis_hsked & (s_axis_tdata != {64{1'b1}});
`else
    assign push = s_axis_hsked;
`endif

    assign empty_after_pop = ((level - {{AW{1'b0}}, pop}) == '0);

    assign o_tx_done    = (state == DONE);
    assign o_frame_cnt  = frame_cnt;
    assign o_fifo_level = level;

    always_ff @(posedge s_axis_aclk) begin
        if (s_axis_areset) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            frame_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= s_axis_tdata;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
                if (frame_cnt != {CNT_W{1'b1}}) begin
                    frame_cnt <= frame_cnt + CNT_W'(1);
                end
            end

            case (state)
                IDLE: begin
                    if (i_tx_sending) begin
                        state     <= RUN;
                        frame_cnt <= '0;
                    end
                end
                RUN: begin
                    if (!i_tx_sending) begin
                        state  <= IDLE;
                        wr_ptr <= '0;
                        rd_ptr <= '0;
                    end else if (s_axis_hsked && s_axis_tlast) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (!i_tx_sending) begin
                        state  <= IDLE;
                        wr_ptr <= '0;
                        rd_ptr <= '0;
                    end else if (empty_after_pop) begin
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_transport_down.sv
// Directed bench for transport_down: reset, basic, backpressure, random handshake, abort and marker filter.
module tb_transport_down;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tlast;
    logic        s_axis_tready;
    logic        s_axis_hsked;
    logic        o_send_valid;
    logic [63:0] o_send_tdata;
    logic        i_send_ready;
    logic        i_tx_sending;
    logic        o_tx_done;
    logic [31:0] o_frame_cnt;
    logic [2:0]  o_fifo_level;

    always #5 clk = ~clk;

    transport_down #(.DEPTH(4), .CNT_W(32)) dut (
        .s_axis_aclk   (clk),
        .s_axis_areset (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .s_axis_hsked  (s_axis_hsked),
        .o_send_valid  (o_send_valid),
        .o_send_tdata  (o_send_tdata),
        .i_send_ready  (i_send_ready),
        .i_tx_sending  (i_tx_sending),
        .o_tx_done     (o_tx_done),
        .o_frame_cnt   (o_frame_cnt),
        .o_fifo_level  (o_fifo_level)
    );

`ifdef TRANSPORT_DOWN_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    int tests = 0;
    int fails = 0;

    logic [63:0] src [256];
    logic [63:0] exp_q [$];
    logic [63:0] rx_q  [$];
    int          done_cnt = 0;
    int          cyc = 0;
    int          hsk_cyc = -1;
    int          vld_cyc = -1;
    int          hold_err = 0;
    bit          hold_en = 1'b1;
    bit          prev_stall = 1'b0;
    logic [63:0] prev_dat = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (o_send_valid && i_send_ready) rx_q.push_back(o_send_tdata);
            if (o_tx_done) done_cnt <= done_cnt + 1;
            if (s_axis_hsked && hsk_cyc < 0) hsk_cyc <= cyc;
            if (o_send_valid && vld_cyc < 0) vld_cyc <= cyc;
            if (hold_en && prev_stall && !(o_send_valid && o_send_tdata == prev_dat))
                hold_err <= hold_err + 1;
        end
        prev_stall <= !rst && o_send_valid && !i_send_ready;
        prev_dat   <= o_send_tdata;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int from, input int total, input int vprob, input int rprob,
                         input int max_cyc, output int nxt);
        int idx = from;
        int c = 0;
        while (idx < total && c < max_cyc) begin
            s_axis_tvalid = (int'($urandom_range(99)) < vprob);
            s_axis_tdata  = src[idx];
            s_axis_tlast  = (idx == total - 1);
            i_send_ready  = (int'($urandom_range(99)) < rprob);
            @(negedge clk);
            if (s_axis_hsked) begin
                if (!(FILT && src[idx] == {64{1'b1}})) exp_q.push_back(src[idx]);
                idx++;
            end
            step();
            c++;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        nxt = idx;
    endtask

    task automatic wait_done(input string tag, input int rprob, input int budget, input int exp_cnt);
        bit seen = 1'b0;
        int c = 0;
        while (!seen && c < budget) begin
            i_send_ready = (int'($urandom_range(99)) < rprob);
            @(negedge clk);
            if (o_tx_done) begin
                seen = 1'b1;
                chk({tag, "_frame_cnt"}, 64'(o_frame_cnt), 64'(exp_cnt));
            end
            step();
            c++;
        end
        chk({tag, "_done_seen"}, 64'(seen), 64'd1);
        i_tx_sending = 1'b0;
        step();
        step();
    endtask

    task automatic sb_check(input string tag, input int exp_len);
        int mism = 0;
        chk({tag, "_len"}, 64'(rx_q.size()), 64'(exp_len));
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
            if (rx_q[i] !== exp_q[i]) mism++;
        chk({tag, "_data"}, 64'(mism), 64'd0);
        rx_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int n;
        int n2;
        rst = 1'b1;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 64'h55;
        s_axis_tlast  = 1'b0;
        i_send_ready  = 1'b1;
        i_tx_sending  = 1'b1;

        // Reset held for three edges with tvalid and tx_sending asserted
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst_tready",  64'(s_axis_tready), 64'd0);
        chk("rst_hsked",   64'(s_axis_hsked),  64'd0);
        chk("rst_valid",   64'(o_send_valid),  64'd0);
        chk("rst_tdata",   o_send_tdata,       64'd0);
        chk("rst_done",    64'(o_tx_done),     64'd0);
        chk("rst_cnt",     64'(o_frame_cnt),   64'd0);
        chk("rst_level",   64'(o_fifo_level),  64'd0);
        step();
        rst = 1'b0;
        s_axis_tvalid = 1'b0;
        step();
        @(negedge clk);
        chk("run_tready",  64'(s_axis_tready), 64'd1);
        chk("run_valid",   64'(o_send_valid),  64'd0);
        step();
        i_tx_sending = 1'b0;
        step();
        step();

        // Basic 8-word transfer
        for (int i = 0; i < 8; i++) src[i] = 64'(i + 1);
        done_cnt = 0; hsk_cyc = -1; vld_cyc = -1;
        i_tx_sending = 1'b1;
        step();
        drive(0, 8, 100, 100, 50, n);
        chk("basic_sent", 64'(n), 64'd8);
        chk("basic_tready_after_last", 64'(s_axis_tready), 64'd0);
        wait_done("basic", 100, 50, 8);
        chk("basic_latency", 64'(vld_cyc - hsk_cyc), 64'd1);
        if (rx_q.size() == 8) begin
            chk("basic_first", rx_q[0], 64'h1);
            chk("basic_last",  rx_q[7], 64'h8);
        end
        sb_check("basic", 8);
        chk("basic_done_pulses", 64'(done_cnt), 64'd1);

        // Backpressure: PAICore stalls, FIFO fills to 4
        for (int i = 0; i < 6; i++) src[i] = 64'(32'h11 + i);
        done_cnt = 0;
        i_tx_sending = 1'b1;
        step();
        drive(0, 6, 100, 0, 8, n);
        chk("bp_pushed",  64'(n), 64'd4);
        chk("bp_level",   64'(o_fifo_level),  64'd4);
        chk("bp_tready",  64'(s_axis_tready), 64'd0);
        chk("bp_head",    o_send_tdata,       64'h11);
        chk("bp_valid",   64'(o_send_valid),  64'd1);
        drive(n, 6, 100, 100, 50, n2);
        chk("bp_sent", 64'(n2), 64'd6);
        wait_done("bp", 100, 50, 6);
        sb_check("bp", 6);
        chk("bp_done_pulses", 64'(done_cnt), 64'd1);

        // Random valid/ready over 200 words
        for (int i = 0; i < 200; i++) src[i] = 64'hA5A5_0000_0000_0000 | 64'(i * 7 + 3);
        done_cnt = 0;
        i_tx_sending = 1'b1;
        step();
        drive(0, 200, 50, 50, 5000, n);
        chk("rnd_sent", 64'(n), 64'd200);
        wait_done("rnd", 50, 2000, 200);
        sb_check("rnd", 200);
        chk("rnd_done_pulses", 64'(done_cnt), 64'd1);

        // Abort with 3 words buffered
        for (int i = 0; i < 3; i++) src[i] = 64'(32'h31 + i);
        done_cnt = 0;
        i_tx_sending = 1'b1;
        step();
        drive(0, 10, 100, 0, 3, n);
        chk("abort_pushed", 64'(n), 64'd3);
        chk("abort_level_before", 64'(o_fifo_level), 64'd3);
        hold_en = 1'b0;
        i_tx_sending = 1'b0;
        @(negedge clk);
        chk("abort_valid_same", 64'(o_send_valid),  64'd0);
        chk("abort_tready_same", 64'(s_axis_tready), 64'd0);
        step();
        chk("abort_level_after", 64'(o_fifo_level), 64'd0);
        chk("abort_valid_after", 64'(o_send_valid), 64'd0);
        step(); step(); step();
        chk("abort_no_done", 64'(done_cnt), 64'd0);
        chk("abort_cnt_held", 64'(o_frame_cnt), 64'd0);
        chk("abort_no_pop", 64'(rx_q.size()), 64'd0);
        rx_q.delete();
        exp_q.delete();
        hold_en = 1'b1;
        src[0] = 64'h41;
        src[1] = 64'h42;
        i_send_ready = 1'b1;
        i_tx_sending = 1'b1;
        step();
        drive(0, 2, 100, 100, 20, n);
        wait_done("abort_new", 100, 50, 2);
        if (rx_q.size() == 2) begin
            chk("abort_new_w0", rx_q[0], 64'h41);
            chk("abort_new_w1", rx_q[1], 64'h42);
        end
        sb_check("abort_new", 2);
        chk("abort_new_done", 64'(done_cnt), 64'd1);

        // All-ones marker words
        src[0] = 64'hA;
        src[1] = {64{1'b1}};
        src[2] = 64'hB;
        src[3] = {64{1'b1}};
        done_cnt = 0;
        i_tx_sending = 1'b1;
        step();
        drive(0, 4, 100, 100, 20, n);
        chk("filt_sent", 64'(n), 64'd4);
        wait_done("filt", 100, 50, FILT ? 2 : 4);
        if (rx_q.size() > 1) begin
            chk("filt_w0", rx_q[0], 64'hA);
            chk("filt_w1", rx_q[1], FILT ? 64'hB : {64{1'b1}});
        end
        sb_check("filt", FILT ? 2 : 4);
        chk("filt_done", 64'(done_cnt), 64'd1);

        chk("hold_stable", 64'(hold_err), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
